// File: rtl/framebuffer_dbl_if.sv
// Frame-store bus: writer port, reader port, swap/clear control and status.
interface framebuffer_dbl_if #(
    parameter int unsigned c_addr_w = 10,
    parameter int unsigned c_bpc    = 12
);
    logic                i_wen;
    logic [c_addr_w-1:0] i_waddr;
    logic [c_bpc-1:0]    i_wdata;
    logic [c_addr_w-1:0] i_raddr;
    logic [c_bpc-1:0]    o_rdata;
    logic                i_swap;
    logic                i_frame_done;
    logic                i_clear;
    logic                o_busy;
    logic                o_swap_pending;
    logic                o_swap_done;
    logic                o_front;

    modport slave (
        input  i_wen, i_waddr, i_wdata, i_raddr, i_swap, i_frame_done, i_clear,
        output o_rdata, o_busy, o_swap_pending, o_swap_done, o_front
    );

    modport master (
        output i_wen, i_waddr, i_wdata, i_raddr, i_swap, i_frame_done, i_clear,
        input  o_rdata, o_busy, o_swap_pending, o_swap_done, o_front
    );
endinterface

// File: rtl/framebuffer_dbl.sv
// Double-buffered LED frame store: writer fills the back bank, reader scans the
// front bank, swaps apply only on a reader frame boundary, back bank can be cleared.
// Optional macro FRAMEBUFFER_TESTPATTERN_EN preloads a bring-up pattern
// (every 4th channel at full scale) into both banks.
module framebuffer_dbl #(
    parameter int unsigned c_ledboards = 30,
    parameter int unsigned c_channels  = c_ledboards * 32,
    parameter int unsigned c_addr_w    = $clog2(c_channels),
    parameter int unsigned c_bpc       = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    framebuffer_dbl_if.slave   bus
);
    localparam int unsigned c_depth = 2 * c_channels;
    localparam int unsigned c_mem_w = $clog2(c_depth);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_PENDING} state_t;
    typedef logic [c_bpc-1:0] mem_t [c_depth];

    // Bank b, channel ch lives at b*c_channels + ch.
    function automatic logic [c_mem_w-1:0] bank_idx(input logic bank,
                                                    input logic [c_addr_w-1:0] ch);
        return bank ? c_mem_w'(ch) + c_mem_w'(c_channels) : c_mem_w'(ch);
    endfunction

`ifdef FRAMEBUFFER_TESTPATTERN_EN
    function automatic mem_t tp_init();
        mem_t m;
        for (int unsigned i = 0; i < c_depth; i++) begin
            m[i] = (((i % c_channels) % 4) == 0) ? '1 : '0;
        end
        return m;
    endfunction
    mem_t mem_q = tp_init();
`else
    mem_t mem_q;
`endif

    state_t              state_q, state_d;
    logic [c_addr_w-1:0] cnt_q, cnt_d;
    logic                swap_q, swap_d;
    logic                front_q, front_d;
    logic                front_last_q, front_last_d;
    logic [c_bpc-1:0]    rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                pend_q, pend_d;
    logic                swap_done_q, swap_done_d;

    logic                mem_we;
    logic [c_mem_w-1:0]  mem_waddr;
    logic [c_bpc-1:0]    mem_wdata;
    logic                wr_ok;

    assign wr_ok = bus.i_wen && (32'(bus.i_waddr) < c_channels);

    // Next-state logic: clear sequencing, swap latching, back-bank write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        swap_d    = swap_q;
        front_d   = front_q;
        mem_we    = 1'b0;
        mem_waddr = bank_idx(~front_q, bus.i_waddr);
        mem_wdata = bus.i_wdata;
        unique case (state_q)
            ST_IDLE: begin
                mem_we = wr_ok;
                if (bus.i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    swap_d  = bus.i_swap;
                end else if (bus.i_swap) begin
                    state_d = ST_PENDING;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = bank_idx(~front_q, cnt_q);
                mem_wdata = '0;
                cnt_d     = cnt_q + c_addr_w'(1);
                if (bus.i_swap) swap_d = 1'b1;
                if (cnt_q == c_addr_w'(c_channels - 1)) begin
                    cnt_d = '0;
                    if (swap_q || bus.i_swap) begin
                        state_d = ST_PENDING;
                        swap_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PENDING: begin
                mem_we = wr_ok;
                if (bus.i_frame_done) begin
                    front_d = ~front_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered output values: read port, status flags, post-swap pulse.
    always_comb begin
        rdata_d      = '0;
        if (32'(bus.i_raddr) < c_channels) rdata_d = mem_q[bank_idx(front_q, bus.i_raddr)];
        busy_d       = (state_d == ST_CLEAR);
        pend_d       = (state_d == ST_PENDING) || swap_d;
        front_last_d = front_q;
        swap_done_d  = (front_q != front_last_q);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            swap_q       <= 1'b0;
            front_q      <= 1'b0;
            front_last_q <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            swap_q       <= swap_d;
            front_q      <= front_d;
            front_last_q <= front_last_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            swap_done_q  <= swap_done_d;
        end
    end

    // Frame memory; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.o_rdata        = rdata_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_swap_pending = pend_q;
    assign bus.o_swap_done    = swap_done_q;
    assign bus.o_front        = front_q;
endmodule
